inst_prefetch_buffer: RTL and testbench

//  Decouples instruction memory from the decode stage, sitting between imem and the core's decoder.

---
 rtl/core_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/inst_prefetch_buffer.sv | 141 ++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-path types and constants for the instruction prefetch slice.
package core_pkg;

   localparam int WORDSZ     = 32;
   localparam int INST_BYTES = 4;

   localparam logic [WORDSZ-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [WORDSZ-1:0] pc;
      logic [WORDSZ-1:0] inst;
   } fetch_entry_t;

   function automatic logic [WORDSZ-1:0] next_fetch_pc(input logic [WORDSZ-1:0] pc);
      return pc + WORDSZ'(INST_BYTES);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous ring-buffer FIFO with flush; used for both the entry queue and the PC tag queue.
module fetch_fifo #(
   parameter int  WIDTH = 64,
   parameter int  DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= ptr_inc(wr_q);
         end
         if (do_pop) rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetcher between imem and decode, with redirect flush/refetch.
// Define PREFETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module inst_prefetch_buffer
   import core_pkg::*;
#(
   parameter int          DEPTH        = 4,
   parameter int          MAX_INFLIGHT = 2,
   parameter logic [31:0] RESET_PC     = 32'h0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        mem_req_valid_o,
   output logic [31:0] mem_req_addr_o,
   input  logic        mem_req_ready_i,
   input  logic        mem_resp_valid_i,
   input  logic [31:0] mem_resp_data_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   input  logic        inst_ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(MAX_INFLIGHT + 1);

   logic [WORDSZ-1:0] fetch_pc_q, fetch_pc_d;
   logic [IW-1:0]     inflight_q, inflight_d;
   logic [IW-1:0]     drop_cnt_q, drop_cnt_d;
   logic              req_valid, req_fire, resp_keep;

   fetch_entry_t      ent_din, ent_dout;
   logic              ent_push, ent_pop, ent_full, ent_empty;
   logic [CW-1:0]     ent_count;

   logic [WORDSZ-1:0] tag_dout;
   logic              tag_push, tag_pop, tag_full, tag_empty;
   logic [IW-1:0]     tag_count;

   // Credit: every word in the queue or in flight owns a slot, so a response always fits.
   assign req_valid = !reset_i && !redirect_i
                      && (inflight_q < IW'(MAX_INFLIGHT))
                      && ((32'(ent_count) + 32'(inflight_q)) < 32'(DEPTH));
   assign req_fire  = req_valid && mem_req_ready_i;

   assign mem_req_valid_o = req_valid;
   assign mem_req_addr_o  = fetch_pc_q;

   assign resp_keep = mem_resp_valid_i && (drop_cnt_q == '0) && !redirect_i;
   assign tag_push  = req_fire;
   assign tag_pop   = resp_keep;

   assign ent_din.pc   = tag_dout;
   assign ent_din.inst = mem_resp_data_i;
   assign ent_pop      = !ent_empty && inst_ready_i && !redirect_i;

`ifdef PREFETCH_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit   = resp_keep && ent_empty;
   assign inst_valid_o = !ent_empty || bypass_hit;
   assign inst_o       = bypass_hit ? mem_resp_data_i : ent_dout.inst;
   assign pc_o         = bypass_hit ? tag_dout : ent_dout.pc;
   assign ent_push     = resp_keep && !(bypass_hit && inst_ready_i);
`else
   assign inst_valid_o = !ent_empty;
   assign inst_o       = ent_dout.inst;
   assign pc_o         = ent_dout.pc;
   assign ent_push     = resp_keep;
`endif

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_cnt_d = drop_cnt_q;
      inflight_d = inflight_q + IW'(req_fire) - IW'(mem_resp_valid_i);
      if (redirect_i) begin
         // Everything still owed by imem after this edge belongs to the old stream.
         fetch_pc_d = redirect_pc_i & ~32'h3;
         drop_cnt_d = inflight_d;
      end else begin
         if (req_fire) fetch_pc_d = next_fetch_pc(fetch_pc_q);
         if (mem_resp_valid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - IW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_entry_q (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (ent_push),
      .pop_i   (ent_pop),
      .flush_i (redirect_i),
      .data_i  (ent_din),
      .data_o  (ent_dout),
      .count_o (ent_count),
      .full_o  (ent_full),
      .empty_o (ent_empty)
   );

   fetch_fifo #(
      .WIDTH (WORDSZ),
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_q (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (tag_push),
      .pop_i   (tag_pop),
      .flush_i (redirect_i),
      .data_i  (fetch_pc_q),
      .data_o  (tag_dout),
      .count_o (tag_count),
      .full_o  (tag_full),
      .empty_o (tag_empty)
   );

   a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
      !(ent_push && ent_full && !ent_pop));
   a_tag_push_ok : assert property (@(posedge clk_i) disable iff (reset_i)
      !(tag_push && tag_full));
   a_tag_pop_ok  : assert property (@(posedge clk_i) disable iff (reset_i)
      !(tag_pop && tag_empty));
   a_tag_balance : assert property (@(posedge clk_i) disable iff (reset_i)
      (32'(tag_count) + 32'(drop_cnt_q)) == 32'(inflight_q));
   a_resp_owed   : assert property (@(posedge clk_i) disable iff (reset_i)
      !(mem_resp_valid_i && (inflight_q == '0)));

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench: imem model with variable latency, scoreboard of expected {pc,inst} drained by a monitor.
module tb_inst_prefetch_buffer;

   logic        clk_i, reset_i;
   logic        mem_req_valid_o, mem_req_ready_i;
   logic [31:0] mem_req_addr_o;
   logic        mem_resp_valid_i;
   logic [31:0] mem_resp_data_i;
   logic        inst_valid_o, inst_ready_i;
   logic [31:0] inst_o, pc_o;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   time         pop_t[$];

   logic [31:0] mq_addr[$];
   int          mq_due[$];
   int          cyc = 0;
   int          lat = 1;
   int          n_acc = 0;
   logic [31:0] resp_addr = '0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = 32'h00A0_0093;

   inst_prefetch_buffer dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .mem_req_valid_o  (mem_req_valid_o),
      .mem_req_addr_o   (mem_req_addr_o),
      .mem_req_ready_i  (mem_req_ready_i),
      .mem_resp_valid_i (mem_resp_valid_i),
      .mem_resp_data_i  (mem_resp_data_i),
      .inst_valid_o     (inst_valid_o),
      .inst_o           (inst_o),
      .pc_o             (pc_o),
      .inst_ready_i     (inst_ready_i),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // imem: accepts on the falling-edge view of valid&ready, answers in order after lat cycles.
   initial begin
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = '0;
      forever begin
         @(posedge clk_i or negedge clk_i or posedge reset_i);
         if (reset_i) begin
            mq_addr.delete();
            mq_due.delete();
            mem_resp_valid_i = 1'b0;
            mem_resp_data_i  = '0;
         end else if (!clk_i) begin
            if (mem_req_valid_o && mem_req_ready_i) begin
               mq_addr.push_back(mem_req_addr_o);
               mq_due.push_back(cyc + lat);
               n_acc++;
            end
         end else begin
            #1;
            cyc++;
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
               resp_addr = mq_addr.pop_front();
               mq_due.delete(0);
               mem_resp_valid_i = 1'b1;
               mem_resp_data_i  = ovr_en ? ovr_data : mk(resp_addr);
            end else begin
               mem_resp_valid_i = 1'b0;
            end
         end
      end
   end

   // Monitor: every accepted decode handshake is compared against the scoreboard head.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk_i);
         if (!reset_i && inst_valid_o && inst_ready_i && !redirect_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_unexpected: got pc %h expected no output", pc_o);
            end else begin
               e = exp_q.pop_front();
               pop_t.push_back($time);
               if (pc_o !== e || inst_o !== mk(e)) begin
                  errors++;
                  $display("FAIL out_entry: got pc %h inst %h expected pc %h inst %h",
                           pc_o, inst_o, e, mk(e));
               end
            end
         end
      end
   end

   task automatic expect_seq(input logic [31:0] start, input int n);
      logic [31:0] p = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(p);
         p = p + 32'd4;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk_i); #2;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_%s: got %0d outputs outstanding expected 0", name, exp_q.size());
         exp_q.delete();
      end
      inst_ready_i = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_i    = 1'b1;
      redirect_pc_i = pc;
      @(posedge clk_i); #2;
      redirect_i    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   initial begin
      int n0, n;
      reset_i         = 1'b1;
      mem_req_ready_i = 1'b1;
      inst_ready_i    = 1'b0;
      redirect_i      = 1'b0;
      redirect_pc_i   = '0;

      // Reset state
      idle(3);
      chk("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("rst_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
      chk("rst_req_addr", mem_req_addr_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_inst", inst_o, 32'h0);

      // Streaming from RESET_PC, one word per cycle once primed
      expect_seq(32'h0, 8);
      pop_t.delete();
      inst_ready_i = 1'b1;
      reset_i      = 1'b0;
      drain("stream");
      chk("stream_rate", (pop_t.size() >= 8) ? 32'(pop_t[7] - pop_t[1]) : 32'd0, 32'd60);

      // Decoder stall: exactly DEPTH words fetched, then requests stop
      idle(10);
      n0 = n_acc;
      redirect_to(32'h40);
      idle(11);
      chk("stall_accepts", 32'(n_acc - n0), 32'd4);
      chk("stall_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
      chk("stall_head_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("stall_head_pc", pc_o, 32'h40);
      expect_seq(32'h40, 8);
      inst_ready_i = 1'b1;
      drain("stall");

      // Two requests outstanding at redirect: both dropped
      idle(8);
      lat = 3;
      redirect_to(32'h10);
      n = 0;
      while (!(mq_addr.size() == 2 && !mem_resp_valid_i) && n < 20) begin
         @(posedge clk_i); #2;
         n++;
      end
      chk("two_inflight", 32'(mq_addr.size()), 32'd2);
      chk("two_inflight_addr", (mq_addr.size() == 2) ? mq_addr[1] : 32'hx, 32'h14);
      expect_seq(32'h100, 4);
      inst_ready_i = 1'b1;
      redirect_to(32'h102);
      drain("drop2");

      // Response in the redirect cycle with one in flight: dropped, no further drops
      mem_req_ready_i = 1'b0;
      idle(10);
      redirect_to(32'h200);
      ovr_en          = 1'b1;
      mem_req_ready_i = 1'b1;
      idle(1);
      mem_req_ready_i = 1'b0;
      n = 0;
      while (!(mem_resp_valid_i && resp_addr == 32'h200) && n < 20) begin
         @(posedge clk_i); #2;
         n++;
      end
      chk("resp_200_seen", {31'b0, mem_resp_valid_i}, 32'd1);
`ifdef PREFETCH_BYPASS_EN
      chk("bypass_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("bypass_pc", pc_o, 32'h200);
      chk("bypass_inst", inst_o, 32'h00A0_0093);
`else
      chk("no_bypass_valid", {31'b0, inst_valid_o}, 32'd0);
`endif
      expect_seq(32'h300, 4);
      redirect_to(32'h300);
      ovr_en          = 1'b0;
      lat             = 1;
      mem_req_ready_i = 1'b1;
      inst_ready_i    = 1'b1;
      drain("redir_resp");

      // Address wrap
      exp_q.push_back(32'hFFFF_FFFC);
      expect_seq(32'h0, 3);
      redirect_to(32'hFFFF_FFFC);
      inst_ready_i = 1'b1;
      drain("wrap");

      // Asynchronous reset between edges mid-stream
      redirect_to(32'h500);
      idle(6);
      chk("prerst_valid", {31'b0, inst_valid_o}, 32'd1);
      reset_i = 1'b1;
      #1;
      chk("arst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("arst_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
      chk("arst_pc", pc_o, 32'h0);
      #1;
      reset_i = 1'b0;
      @(negedge clk_i); #1;
      chk("postrst_req_valid", {31'b0, mem_req_valid_o}, 32'd1);
      chk("postrst_req_addr", mem_req_addr_o, 32'h0);
      @(posedge clk_i); #2;
      expect_seq(32'h0, 4);
      inst_ready_i = 1'b1;
      drain("after_reset");

      idle(4);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
